// File: rtl/mem_issue_queue_gen_if.sv
// mem_issue_queue_gen_if: dispatch, issue, feedback, wakeup and flush bundle of the memory issue queue
interface mem_issue_queue_gen_if #(
   parameter int DEPTH   = 16,
   parameter int PORTS   = 2,
   parameter int NUMSRCS = 2,
   parameter int EXT_WK  = 4,
   parameter int STU_NUM = 2,
   parameter int PR_W    = 7,
   parameter int ROB_W   = 7,
   parameter int UOP_W   = 64
);
   localparam int IW = $clog2(DEPTH);
   logic                          o_can_enq;
   logic [PORTS-1:0]              i_enq_req;
   logic [PORTS*UOP_W-1:0]        i_enq_uop;
   logic [PORTS*ROB_W-1:0]        i_enq_robIdx;
   logic [PORTS*ROB_W-1:0]        i_enq_depIdx;
   logic [PORTS*NUMSRCS*PR_W-1:0] i_enq_iprs;
   logic [PORTS*NUMSRCS-1:0]      i_enq_src_rdy;
   logic [PORTS-1:0]              i_enq_dep_rdy;
   logic [PORTS-1:0]              i_fu_busy;
   logic [PORTS-1:0]              o_can_issue;
   logic [PORTS*UOP_W-1:0]        o_issue_uop;
   logic [PORTS*ROB_W-1:0]        o_issue_robIdx;
   logic [PORTS*IW-1:0]           o_issue_iqIdx;
   logic [PORTS-1:0]              i_fb_success;
   logic [PORTS-1:0]              i_fb_replay;
   logic [PORTS*IW-1:0]           i_fb_idx;
   logic [STU_NUM-1:0]            i_stu_wk;
   logic [STU_NUM*ROB_W-1:0]      i_stu_wk_robIdx;
   logic [EXT_WK-1:0]             i_ext_wk_vec;
   logic [EXT_WK*PR_W-1:0]        i_ext_wk_iprd;
   logic                          i_flush;
   logic [ROB_W-1:0]              i_flush_robIdx;
   logic [IW:0]                   o_occupancy;
   modport slave (
      output o_can_enq, o_can_issue, o_issue_uop, o_issue_robIdx, o_issue_iqIdx, o_occupancy,
      input  i_enq_req, i_enq_uop, i_enq_robIdx, i_enq_depIdx, i_enq_iprs, i_enq_src_rdy,
             i_enq_dep_rdy, i_fu_busy, i_fb_success, i_fb_replay, i_fb_idx, i_stu_wk,
             i_stu_wk_robIdx, i_ext_wk_vec, i_ext_wk_iprd, i_flush, i_flush_robIdx
   );
   modport master (
      input  o_can_enq, o_can_issue, o_issue_uop, o_issue_robIdx, o_issue_iqIdx, o_occupancy,
      output i_enq_req, i_enq_uop, i_enq_robIdx, i_enq_depIdx, i_enq_iprs, i_enq_src_rdy,
             i_enq_dep_rdy, i_fu_busy, i_fb_success, i_fb_replay, i_fb_idx, i_stu_wk,
             i_stu_wk_robIdx, i_ext_wk_vec, i_ext_wk_iprd, i_flush, i_flush_robIdx
   );
endinterface

// File: rtl/mem_issue_queue_gen.sv
// mem_issue_queue_gen: unordered load/store reservation station with oldest-first multi-port select
module mem_issue_queue_gen #(
   parameter int DEPTH   = 16,
   parameter int PORTS   = 2,
   parameter int NUMSRCS = 2,
   parameter int EXT_WK  = 4,
   parameter int STU_NUM = 2,
   parameter int PR_W    = 7,
   parameter int ROB_W   = 7,
   parameter int UOP_W   = 64
) (
   input logic clk,
   input logic rst,
   mem_issue_queue_gen_if.slave io
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   logic [DEPTH-1:0]        vld, issued, dep_rdy, ndep, rdy, kill, nvld;
   logic [NUMSRCS-1:0]      src_rdy [DEPTH];
   logic [NUMSRCS-1:0]      nsrc [DEPTH];
   logic [ROB_W-1:0]        rob [DEPTH];
   logic [ROB_W-1:0]        dep [DEPTH];
   logic [NUMSRCS*PR_W-1:0] iprs [DEPTH];
   logic [UOP_W-1:0]        uop [DEPTH];
   logic [CW-1:0]           rank [DEPTH];
   logic [CW-1:0]           occ, occ_n, fr, fc;
   logic [PORTS-1:0]        sel_v, fire, enq_dep, enq_kill;
   logic [IW-1:0]           sel_idx [PORTS];
   logic [IW-1:0]           enq_idx [PORTS];
   logic [IW-1:0]           fb_idx [PORTS];
   logic [NUMSRCS-1:0]      enq_src [PORTS];
   logic                    can_enq;

   // MSB of a ROB index is the wrap flag
   function automatic logic older(input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] b);
      return (a[ROB_W-1] == b[ROB_W-1]) ? (a[ROB_W-2:0] < b[ROB_W-2:0]) : (a[ROB_W-2:0] > b[ROB_W-2:0]);
   endfunction

   assign can_enq = (CW'(DEPTH) - occ) >= CW'(PORTS);
   assign io.o_can_enq = can_enq;
   assign io.o_occupancy = occ;

   always_comb begin
      for (int e = 0; e < DEPTH; e++) begin
         ndep[e] = dep_rdy[e];
         for (int c = 0; c < STU_NUM; c++)
            ndep[e] = ndep[e] | (io.i_stu_wk[c] && io.i_stu_wk_robIdx[c*ROB_W +: ROB_W] == dep[e]);
         for (int s = 0; s < NUMSRCS; s++) begin
            nsrc[e][s] = src_rdy[e][s];
            for (int w = 0; w < EXT_WK; w++)
               nsrc[e][s] = nsrc[e][s] | (io.i_ext_wk_vec[w] && io.i_ext_wk_iprd[w*PR_W +: PR_W] == iprs[e][s*PR_W +: PR_W]);
         end
         rdy[e] = vld[e] & ~issued[e] & (&nsrc[e]) & ndep[e];
         kill[e] = io.i_flush & ~older(rob[e], io.i_flush_robIdx);
      end
   end

   // rank = number of ready entries older than this one; index breaks age ties
   always_comb begin
      for (int e = 0; e < DEPTH; e++) begin
         rank[e] = '0;
         for (int f = 0; f < DEPTH; f++)
            if (f != e && rdy[f] && (older(rob[f], rob[e]) || (rob[f] == rob[e] && f < e)))
               rank[e] = rank[e] + 1'b1;
      end
   end

   always_comb begin
      fr = '0;
      for (int p = 0; p < PORTS; p++) begin
         sel_v[p] = 1'b0;
         sel_idx[p] = '0;
         for (int e = 0; e < DEPTH; e++)
            if (!io.i_fu_busy[p] && rdy[e] && rank[e] == fr) begin
               sel_v[p] = 1'b1;
               sel_idx[p] = IW'(e);
            end
         fr = fr + CW'(!io.i_fu_busy[p]);
      end
   end

   always_comb begin
      fc = '0;
      for (int p = 0; p < PORTS; p++) enq_idx[p] = '0;
      for (int e = 0; e < DEPTH; e++)
         if (!vld[e]) begin
            for (int p = 0; p < PORTS; p++)
               if (fc == CW'(p)) enq_idx[p] = IW'(e);
            fc = fc + 1'b1;
         end
   end

   always_comb begin
      for (int p = 0; p < PORTS; p++) begin
         fire[p] = io.i_enq_req[p] & can_enq;
         fb_idx[p] = io.i_fb_idx[p*IW +: IW];
         enq_kill[p] = io.i_flush & ~older(io.i_enq_robIdx[p*ROB_W +: ROB_W], io.i_flush_robIdx);
         enq_dep[p] = io.i_enq_dep_rdy[p];
         for (int c = 0; c < STU_NUM; c++)
            enq_dep[p] = enq_dep[p] | (io.i_stu_wk[c] && io.i_stu_wk_robIdx[c*ROB_W +: ROB_W] == io.i_enq_depIdx[p*ROB_W +: ROB_W]);
         for (int s = 0; s < NUMSRCS; s++) begin
            enq_src[p][s] = io.i_enq_src_rdy[p*NUMSRCS+s];
            for (int w = 0; w < EXT_WK; w++)
               enq_src[p][s] = enq_src[p][s] | (io.i_ext_wk_vec[w] && io.i_ext_wk_iprd[w*PR_W +: PR_W] == io.i_enq_iprs[(p*NUMSRCS+s)*PR_W +: PR_W]);
         end
      end
      nvld = vld & ~kill;
      for (int p = 0; p < PORTS; p++)
         if (io.i_fb_success[p]) nvld[fb_idx[p]] = 1'b0;
      for (int p = 0; p < PORTS; p++)
         if (fire[p]) nvld[enq_idx[p]] = ~enq_kill[p];
      occ_n = '0;
      for (int e = 0; e < DEPTH; e++) occ_n = occ_n + CW'(nvld[e]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         issued <= '0;
         occ <= '0;
         io.o_can_issue <= '0;
         io.o_issue_uop <= '0;
         io.o_issue_robIdx <= '0;
         io.o_issue_iqIdx <= '0;
      end else begin
         vld <= nvld;
         occ <= occ_n;
         dep_rdy <= ndep;
         for (int e = 0; e < DEPTH; e++) src_rdy[e] <= nsrc[e];
         for (int p = 0; p < PORTS; p++)
            if (io.i_fb_replay[p] && !io.i_fb_success[p]) issued[fb_idx[p]] <= 1'b0;
         for (int p = 0; p < PORTS; p++)
            if (sel_v[p] && !io.i_flush) issued[sel_idx[p]] <= 1'b1;
         for (int p = 0; p < PORTS; p++)
            if (fire[p]) begin
               issued[enq_idx[p]] <= 1'b0;
               src_rdy[enq_idx[p]] <= enq_src[p];
               dep_rdy[enq_idx[p]] <= enq_dep[p];
               rob[enq_idx[p]] <= io.i_enq_robIdx[p*ROB_W +: ROB_W];
               dep[enq_idx[p]] <= io.i_enq_depIdx[p*ROB_W +: ROB_W];
               iprs[enq_idx[p]] <= io.i_enq_iprs[p*NUMSRCS*PR_W +: NUMSRCS*PR_W];
               uop[enq_idx[p]] <= io.i_enq_uop[p*UOP_W +: UOP_W];
            end
         for (int p = 0; p < PORTS; p++) begin
            io.o_can_issue[p] <= sel_v[p] & ~io.i_flush;
            io.o_issue_uop[p*UOP_W +: UOP_W] <= uop[sel_idx[p]];
            io.o_issue_robIdx[p*ROB_W +: ROB_W] <= rob[sel_idx[p]];
            io.o_issue_iqIdx[p*IW +: IW] <= sel_idx[p];
         end
      end
   end

   for (genvar p = 0; p < PORTS; p++) begin : g_fb
      a_fb_vld: assert property (@(posedge clk) disable iff (rst)
         (io.i_fb_success[p] || io.i_fb_replay[p]) |-> vld[fb_idx[p]]);
   end
endmodule

// File: tb/tb_mem_issue_queue_gen.sv
// tb_mem_issue_queue_gen: directed scenarios for the memory issue queue with hand-computed expectations
module tb_mem_issue_queue_gen;
   logic clk = 1'b0;
   logic rst;
   int vec = 0;
   int errs = 0;

   always #5 clk = ~clk;

   mem_issue_queue_gen_if io ();
   mem_issue_queue_gen dut (.clk(clk), .rst(rst), .io(io.slave));

   function automatic logic [63:0] uop_of(input logic [6:0] r);
      return 64'hC0DE_0000_0000_0000 | 64'(r);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      io.i_enq_req = '0; io.i_enq_uop = '0; io.i_enq_robIdx = '0; io.i_enq_depIdx = '0;
      io.i_enq_iprs = '0; io.i_enq_src_rdy = '0; io.i_enq_dep_rdy = '0; io.i_fu_busy = '0;
      io.i_fb_success = '0; io.i_fb_replay = '0; io.i_fb_idx = '0; io.i_stu_wk = '0;
      io.i_stu_wk_robIdx = '0; io.i_ext_wk_vec = '0; io.i_ext_wk_iprd = '0;
      io.i_flush = 1'b0; io.i_flush_robIdx = '0;
   endtask

   task automatic do_reset;
      idle;
      rst = 1'b1;
      tick;
      rst = 1'b0;
   endtask

   task automatic set_enq(input int p, input logic [6:0] r, d, ip0, ip1, input logic [1:0] sr, input logic dr);
      io.i_enq_req[p] = 1'b1;
      io.i_enq_uop[p*64 +: 64] = uop_of(r);
      io.i_enq_robIdx[p*7 +: 7] = r;
      io.i_enq_depIdx[p*7 +: 7] = d;
      io.i_enq_iprs[p*14 +: 14] = {ip1, ip0};
      io.i_enq_src_rdy[p*2 +: 2] = sr;
      io.i_enq_dep_rdy[p] = dr;
   endtask

   task automatic test_reset;
      idle;
      rst = 1'b1;
      io.i_enq_req = 2'b11;
      tick;
      tick;
      io.i_enq_req = 2'b00;
      vec++; if (io.o_can_issue !== 2'b00) begin errs++; $display("FAIL reset_can_issue got %b want 00", io.o_can_issue); end
      vec++; if (io.o_occupancy !== 5'd0) begin errs++; $display("FAIL reset_occ got %0d want 0", io.o_occupancy); end
      vec++; if (io.o_can_enq !== 1'b1) begin errs++; $display("FAIL reset_can_enq got %b want 1", io.o_can_enq); end
      vec++; if (io.o_issue_robIdx !== 14'd0) begin errs++; $display("FAIL reset_robIdx got %h want 0", io.o_issue_robIdx); end
      vec++; if (io.o_issue_uop !== 128'd0) begin errs++; $display("FAIL reset_uop got %h want 0", io.o_issue_uop); end
      rst = 1'b0;
   endtask

   task automatic test_dual_issue;
      do_reset;
      set_enq(0, 7'd5, 7'd0, 7'd1, 7'd2, 2'b11, 1'b1);
      set_enq(1, 7'd3, 7'd0, 7'd3, 7'd4, 2'b11, 1'b1);
      tick;
      idle;
      vec++; if (io.o_occupancy !== 5'd2) begin errs++; $display("FAIL dual_occ got %0d want 2", io.o_occupancy); end
      tick;
      vec++; if (io.o_can_issue !== 2'b11) begin errs++; $display("FAIL dual_can_issue got %b want 11", io.o_can_issue); end
      vec++; if (io.o_issue_robIdx !== {7'd5, 7'd3}) begin errs++; $display("FAIL dual_robIdx got %h want %h", io.o_issue_robIdx, {7'd5, 7'd3}); end
      vec++; if (io.o_issue_iqIdx !== {4'd0, 4'd1}) begin errs++; $display("FAIL dual_iqIdx got %h want 01", io.o_issue_iqIdx); end
      vec++; if (io.o_issue_uop[63:0] !== uop_of(7'd3)) begin errs++; $display("FAIL dual_uop got %h want %h", io.o_issue_uop[63:0], uop_of(7'd3)); end
      io.i_fb_success = 2'b11;
      io.i_fb_idx = {4'd1, 4'd0};
      tick;
      idle;
      vec++; if (io.o_occupancy !== 5'd0) begin errs++; $display("FAIL dual_free_occ got %0d want 0", io.o_occupancy); end
      vec++; if (io.o_can_issue !== 2'b00) begin errs++; $display("FAIL dual_no_reissue got %b want 00", io.o_can_issue); end
   endtask

   task automatic test_busy;
      do_reset;
      set_enq(0, 7'd5, 7'd0, 7'd1, 7'd2, 2'b11, 1'b1);
      set_enq(1, 7'd3, 7'd0, 7'd3, 7'd4, 2'b11, 1'b1);
      io.i_fu_busy = 2'b01;
      tick;
      io.i_enq_req = 2'b00;
      tick;
      vec++; if (io.o_can_issue !== 2'b10) begin errs++; $display("FAIL busy_can_issue got %b want 10", io.o_can_issue); end
      vec++; if (io.o_issue_robIdx[13:7] !== 7'd3) begin errs++; $display("FAIL busy_p1_robIdx got %0d want 3", io.o_issue_robIdx[13:7]); end
      io.i_fu_busy = 2'b00;
      tick;
      vec++; if (io.o_can_issue !== 2'b01) begin errs++; $display("FAIL busy_next_can_issue got %b want 01", io.o_can_issue); end
      vec++; if (io.o_issue_robIdx[6:0] !== 7'd5) begin errs++; $display("FAIL busy_p0_robIdx got %0d want 5", io.o_issue_robIdx[6:0]); end
   endtask

   task automatic test_ext_wakeup;
      do_reset;
      set_enq(0, 7'd12, 7'd0, 7'd10, 7'd42, 2'b01, 1'b1);
      tick;
      idle;
      io.i_ext_wk_vec = 4'b0001;
      io.i_ext_wk_iprd[6:0] = 7'd41;
      tick;
      idle;
      tick;
      vec++; if (io.o_can_issue !== 2'b00) begin errs++; $display("FAIL ext_wait got %b want 00", io.o_can_issue); end
      io.i_ext_wk_vec = 4'b0100;
      io.i_ext_wk_iprd[20:14] = 7'd42;
      tick;
      idle;
      vec++; if (io.o_can_issue !== 2'b01) begin errs++; $display("FAIL ext_issue got %b want 01", io.o_can_issue); end
      vec++; if (io.o_issue_uop[63:0] !== uop_of(7'd12)) begin errs++; $display("FAIL ext_uop got %h want %h", io.o_issue_uop[63:0], uop_of(7'd12)); end
      vec++; if (io.o_issue_iqIdx[3:0] !== 4'd0) begin errs++; $display("FAIL ext_iqIdx got %0d want 0", io.o_issue_iqIdx[3:0]); end
      io.i_fb_replay = 2'b01;
      io.i_fb_idx = 8'd0;
      tick;
      idle;
      vec++; if (io.o_can_issue !== 2'b00) begin errs++; $display("FAIL ext_replay_gap got %b want 00", io.o_can_issue); end
      tick;
      vec++; if (io.o_can_issue !== 2'b01) begin errs++; $display("FAIL ext_reissue got %b want 01", io.o_can_issue); end
      vec++; if (io.o_occupancy !== 5'd1) begin errs++; $display("FAIL ext_occ_before got %0d want 1", io.o_occupancy); end
      io.i_fb_success = 2'b01;
      io.i_fb_idx = 8'd0;
      tick;
      idle;
      vec++; if (io.o_occupancy !== 5'd0) begin errs++; $display("FAIL ext_occ_after got %0d want 0", io.o_occupancy); end
   endtask

   task automatic test_enq_wakeup;
      do_reset;
      set_enq(0, 7'd30, 7'd0, 7'd10, 7'd42, 2'b01, 1'b1);
      set_enq(1, 7'd31, 7'd9, 7'd11, 7'd12, 2'b11, 1'b0);
      io.i_ext_wk_vec = 4'b0001;
      io.i_ext_wk_iprd[6:0] = 7'd42;
      io.i_stu_wk = 2'b10;
      io.i_stu_wk_robIdx[13:7] = 7'd9;
      tick;
      idle;
      vec++; if (io.o_can_issue !== 2'b00) begin errs++; $display("FAIL enqwk_first got %b want 00", io.o_can_issue); end
      tick;
      vec++; if (io.o_can_issue !== 2'b11) begin errs++; $display("FAIL enqwk_issue got %b want 11", io.o_can_issue); end
   endtask

   task automatic test_memdep;
      do_reset;
      set_enq(0, 7'd20, 7'd9, 7'd1, 7'd2, 2'b11, 1'b0);
      tick;
      idle;
      tick;
      vec++; if (io.o_can_issue !== 2'b00) begin errs++; $display("FAIL memdep_wait got %b want 00", io.o_can_issue); end
      io.i_stu_wk = 2'b01;
      io.i_stu_wk_robIdx[6:0] = 7'd8;
      tick;
      idle;
      vec++; if (io.o_can_issue !== 2'b00) begin errs++; $display("FAIL memdep_wrong_wk got %b want 00", io.o_can_issue); end
      io.i_stu_wk = 2'b10;
      io.i_stu_wk_robIdx[13:7] = 7'd9;
      tick;
      idle;
      vec++; if (io.o_can_issue !== 2'b01) begin errs++; $display("FAIL memdep_issue got %b want 01", io.o_can_issue); end
      vec++; if (io.o_issue_robIdx[6:0] !== 7'd20) begin errs++; $display("FAIL memdep_robIdx got %0d want 20", io.o_issue_robIdx[6:0]); end
   endtask

   task automatic test_wrap;
      logic [6:0] exp_rob [4];
      exp_rob = '{7'h7E, 7'h7F, 7'h00, 7'h01};
      do_reset;
      set_enq(0, 7'h00, 7'd0, 7'd1, 7'd2, 2'b11, 1'b1);
      set_enq(1, 7'h7F, 7'd0, 7'd1, 7'd2, 2'b11, 1'b1);
      io.i_fu_busy = 2'b11;
      tick;
      set_enq(0, 7'h01, 7'd0, 7'd1, 7'd2, 2'b11, 1'b1);
      set_enq(1, 7'h7E, 7'd0, 7'd1, 7'd2, 2'b11, 1'b1);
      tick;
      idle;
      io.i_fu_busy = 2'b10;
      for (int i = 0; i < 4; i++) begin
         tick;
         vec++; if (io.o_can_issue !== 2'b01) begin errs++; $display("FAIL wrap_can_issue[%0d] got %b want 01", i, io.o_can_issue); end
         vec++; if (io.o_issue_robIdx[6:0] !== exp_rob[i]) begin errs++; $display("FAIL wrap_order[%0d] got %h want %h", i, io.o_issue_robIdx[6:0], exp_rob[i]); end
      end
   endtask

   task automatic test_full_flush;
      do_reset;
      io.i_fu_busy = 2'b11;
      for (int i = 0; i < 7; i++) begin
         set_enq(0, 7'(8 + 2*i), 7'd0, 7'd1, 7'd2, 2'b11, 1'b1);
         set_enq(1, 7'(9 + 2*i), 7'd0, 7'd1, 7'd2, 2'b11, 1'b1);
         tick;
      end
      io.i_enq_req = 2'b00;
      set_enq(0, 7'd22, 7'd0, 7'd1, 7'd2, 2'b11, 1'b1);
      tick;
      io.i_enq_req = 2'b00;
      vec++; if (io.o_occupancy !== 5'd15) begin errs++; $display("FAIL full_occ got %0d want 15", io.o_occupancy); end
      vec++; if (io.o_can_enq !== 1'b0) begin errs++; $display("FAIL full_can_enq got %b want 0", io.o_can_enq); end
      set_enq(0, 7'd40, 7'd0, 7'd1, 7'd2, 2'b11, 1'b1);
      set_enq(1, 7'd41, 7'd0, 7'd1, 7'd2, 2'b11, 1'b1);
      tick;
      io.i_enq_req = 2'b00;
      vec++; if (io.o_occupancy !== 5'd15) begin errs++; $display("FAIL full_ignore got %0d want 15", io.o_occupancy); end
      io.i_fu_busy = 2'b00;
      io.i_flush = 1'b1;
      io.i_flush_robIdx = 7'd10;
      tick;
      idle;
      vec++; if (io.o_occupancy !== 5'd2) begin errs++; $display("FAIL flush_occ got %0d want 2", io.o_occupancy); end
      vec++; if (io.o_can_issue !== 2'b00) begin errs++; $display("FAIL flush_can_issue got %b want 00", io.o_can_issue); end
      vec++; if (io.o_can_enq !== 1'b1) begin errs++; $display("FAIL flush_can_enq got %b want 1", io.o_can_enq); end
      tick;
      vec++; if (io.o_can_issue !== 2'b11) begin errs++; $display("FAIL flush_survivors got %b want 11", io.o_can_issue); end
      vec++; if (io.o_issue_robIdx !== {7'd9, 7'd8}) begin errs++; $display("FAIL flush_robIdx got %h want %h", io.o_issue_robIdx, {7'd9, 7'd8}); end
   endtask

   task automatic test_rst_mid;
      do_reset;
      set_enq(0, 7'd50, 7'd0, 7'd1, 7'd2, 2'b11, 1'b1);
      set_enq(1, 7'd51, 7'd0, 7'd1, 7'd2, 2'b11, 1'b1);
      tick;
      idle;
      rst = 1'b1;
      set_enq(0, 7'd52, 7'd0, 7'd1, 7'd2, 2'b11, 1'b1);
      tick;
      rst = 1'b0;
      idle;
      vec++; if (io.o_can_issue !== 2'b00) begin errs++; $display("FAIL rstmid_can_issue got %b want 00", io.o_can_issue); end
      vec++; if (io.o_occupancy !== 5'd0) begin errs++; $display("FAIL rstmid_occ got %0d want 0", io.o_occupancy); end
      vec++; if (io.o_can_enq !== 1'b1) begin errs++; $display("FAIL rstmid_can_enq got %b want 1", io.o_can_enq); end
      tick;
      vec++; if (io.o_can_issue !== 2'b00) begin errs++; $display("FAIL rstmid_after got %b want 00", io.o_can_issue); end
   endtask

   initial begin
      rst = 1'b1;
      idle;
      test_reset;
      test_dual_issue;
      test_busy;
      test_ext_wakeup;
      test_enq_wakeup;
      test_memdep;
      test_wrap;
      test_full_flush;
      test_rst_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
